// File: rtl/mp3player_soc_leds_out.sv
// Avalon-MM output PIO driving board LEDs, with atomic set/clear and a per-bit blink engine.
// Blink engine (BLINK_MASK, DIVISOR, counter, phase) is built only when MP3PLAYER_LEDS_BLINK_EN is defined.
module mp3player_soc_leds_out #(
  parameter int unsigned WIDTH       = 10,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter logic [31:0] DIV_RESET   = 32'd25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLR    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic             wr_c;
  logic [WIDTH-1:0] wd_c;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      readdata_q, readdata_d;

  assign wr_c = chipselect & ~write_n;
  assign wd_c = writedata[WIDTH-1:0];

  // DATA register: direct write, OR-set and AND-NOT-clear
  always_comb begin
    data_d = data_q;
    if (wr_c) begin
      case (address)
        ADDR_DATA: data_d = wd_c;
        ADDR_SET:  data_d = data_q | wd_c;
        ADDR_CLR:  data_d = data_q & ~wd_c;
        default:   data_d = data_q;
      endcase
    end
  end

`ifdef MP3PLAYER_LEDS_BLINK_EN
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_DIV  = 3'd4;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      div_q, div_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // A DIVISOR write restarts the period in the on phase; DIVISOR==0 parks it on
  always_comb begin
    mask_d  = mask_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_c && address == ADDR_MASK) begin
      mask_d = wd_c;
    end
    if (wr_c && address == ADDR_DIV) begin
      div_d   = writedata;
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end else if (div_q == 32'd0) begin
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end else if (cnt_q == div_q - 32'd1) begin
      cnt_d   = 32'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign out_d = data_d & ~(mask_d & {WIDTH{~phase_d}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      div_q   <= DIV_RESET;
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else begin
      mask_q  <= mask_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_wd_c;

  assign unused_wd_c = ^writedata;
  assign out_d       = data_d;
`endif

  // Read mux samples register state before any same-cycle write
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA:   readdata_d = 32'(data_q);
`ifdef MP3PLAYER_LEDS_BLINK_EN
      ADDR_MASK:   readdata_d = 32'(mask_q);
      ADDR_DIV:    readdata_d = div_q;
`endif
      ADDR_STATUS: readdata_d = 32'(out_q);
      default:     readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= WIDTH'(RESET_VALUE);
      out_q      <= WIDTH'(RESET_VALUE);
      readdata_q <= 32'd0;
    end else begin
      data_q     <= data_d;
      out_q      <= out_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_mp3player_soc_leds_out.sv
// Scoreboard bench for mp3player_soc_leds_out; covers both MP3PLAYER_LEDS_BLINK_EN builds.
module tb_mp3player_soc_leds_out;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  typedef struct {
    string       name;
    int          at;
    bit          rd_chk;
    logic [31:0] rd;
    bit          out_chk;
    logic [9:0]  out;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mp3player_soc_leds_out #(
    .WIDTH(10),
    .RESET_VALUE(32'h155),
    .DIV_RESET(32'd25000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chipselect(chipselect),
    .address(address),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle, flag any that were skipped
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        if (sb[i].rd_chk) begin
          checks++;
          if (readdata !== sb[i].rd) begin
            failures++;
            $display("FAIL %s readdata got=%h exp=%h (cycle %0d)", sb[i].name, readdata, sb[i].rd, cyc);
          end
        end
        if (sb[i].out_chk) begin
          checks++;
          if (out_port !== sb[i].out) begin
            failures++;
            $display("FAIL %s out_port got=%h exp=%h (cycle %0d)", sb[i].name, out_port, sb[i].out, cyc);
          end
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s not checked at cycle %0d (now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  int eff;

  // One bus cycle driven at the negedge; eff is the rising edge that samples it
  task automatic step(input bit rst, input bit cs, input logic [2:0] a, input bit wr, input logic [31:0] d);
    @(negedge clk);
    reset      = rst;
    chipselect = cs;
    address    = a;
    write_n    = ~wr;
    writedata  = d;
    eff        = cyc + 1;
  endtask

  task automatic bus(input logic [2:0] a, input bit wr, input logic [31:0] d);
    step(1'b0, 1'b1, a, wr, d);
  endtask

  task automatic expect_at(input string nm, input bit rc, input logic [31:0] rd,
                           input bit oc, input logic [9:0] o);
    exp_t e;
    e.name = nm; e.at = eff; e.rd_chk = rc; e.rd = rd; e.out_chk = oc; e.out = o;
    sb.push_back(e);
  endtask

`ifdef MP3PLAYER_LEDS_BLINK_EN
  function automatic logic [9:0] blink_out(input int k);
    return (((k / 4) % 2) == 0) ? 10'h3FF : 10'h3FE;
  endfunction
  int e2;
  int f;
`endif

  initial begin
    reset = 1'b1; chipselect = 1'b0; address = 3'd0; write_n = 1'b1; writedata = 32'd0;

    step(1'b1, 1'b0, 3'd0, 1'b0, 32'd0); expect_at("reset_a", 1, 32'd0, 1, 10'h155);
    step(1'b1, 1'b1, 3'd0, 1'b0, 32'd0); expect_at("reset_b", 1, 32'd0, 1, 10'h155);
    bus(3'd0, 0, 32'd0); expect_at("reset_data_rd", 1, 32'h155, 1, 10'h155);
    bus(3'd4, 0, 32'd0);
`ifdef MP3PLAYER_LEDS_BLINK_EN
    expect_at("reset_div_rd", 1, 32'd25000000, 1, 10'h155);
`else
    expect_at("reset_div_rd", 1, 32'd0, 1, 10'h155);
`endif

    // DATA write: readdata shows pre-write value, out_port follows next edge
    bus(3'd0, 1, 32'h3FF);       expect_at("data_wr1", 1, 32'h155, 1, 10'h3FF);
    bus(3'd0, 1, 32'hFFFFFC00);  expect_at("data_wr_upper", 1, 32'h3FF, 1, 10'h000);
    bus(3'd0, 0, 32'd0);         expect_at("data_rd0", 1, 32'h000, 1, 10'h000);

    // Set / clear
    bus(3'd0, 1, 32'h0F0);       expect_at("pre_set", 0, 32'd0, 1, 10'h0F0);
    bus(3'd2, 1, 32'h00F);       expect_at("outset", 1, 32'd0, 1, 10'h0FF);
    bus(3'd3, 1, 32'h0F0);       expect_at("outclear", 1, 32'd0, 1, 10'h00F);
    bus(3'd2, 0, 32'd0);         expect_at("outset_rd", 1, 32'd0, 1, 10'h00F);
    bus(3'd0, 0, 32'd0);         expect_at("data_after_setclr", 1, 32'h00F, 1, 10'h00F);
    bus(3'd2, 1, 32'd0);         expect_at("outset_zero", 0, 32'd0, 1, 10'h00F);
    bus(3'd3, 1, 32'd0);         expect_at("outclear_zero", 1, 32'd0, 1, 10'h00F);
    bus(3'd5, 0, 32'd0);         expect_at("status_rd", 1, 32'h00F, 1, 10'h00F);
    bus(3'd6, 1, 32'hFFFF);      expect_at("rsvd6_wr", 1, 32'd0, 1, 10'h00F);
    bus(3'd7, 0, 32'd0);         expect_at("rsvd7_rd", 1, 32'd0, 1, 10'h00F);

`ifdef MP3PLAYER_LEDS_BLINK_EN
    bus(3'd0, 1, 32'h3FF);       expect_at("blink_data", 0, 32'd0, 1, 10'h3FF);
    bus(3'd1, 1, 32'h001);       expect_at("blink_mask", 0, 32'd0, 1, 10'h3FF);
    bus(3'd4, 1, 32'd4);         expect_at("blink_div4", 0, 32'd0, 1, 10'h3FF);
    e2 = eff;
    for (int k = 1; k <= 21; k++) begin
      bus(3'd5, 0, 32'd0);
      expect_at("blink4", 1, 32'(blink_out(eff - e2 - 1)), 1, blink_out(eff - e2));
    end
    bus(3'd4, 1, 32'd0);         expect_at("div0_wr", 1, 32'd4, 1, 10'h3FF);
    for (int j = 0; j < 6; j++) begin
      bus(3'd5, 0, 32'd0);       expect_at("div0_hold", 1, 32'h3FF, 1, 10'h3FF);
    end
    bus(3'd1, 0, 32'd0);         expect_at("mask_rd", 1, 32'h001, 1, 10'h3FF);
    bus(3'd4, 1, 32'd1);         expect_at("div1_wr", 0, 32'd0, 1, 10'h3FF);
    f = eff;
    for (int j = 1; j <= 8; j++) begin
      bus(3'd5, 0, 32'd0);
      expect_at("div1_toggle", 1, (((eff - f - 1) % 2) == 0) ? 32'h3FF : 32'h3FE, 1,
                (((eff - f) % 2) == 0) ? 10'h3FF : 10'h3FE);
    end
`else
    bus(3'd1, 1, 32'h001);       expect_at("nb_mask_wr", 0, 32'd0, 1, 10'h00F);
    bus(3'd4, 1, 32'd4);         expect_at("nb_div_wr", 0, 32'd0, 1, 10'h00F);
    bus(3'd1, 0, 32'd0);         expect_at("nb_mask_rd", 1, 32'd0, 1, 10'h00F);
    bus(3'd4, 0, 32'd0);         expect_at("nb_div_rd", 1, 32'd0, 1, 10'h00F);
    for (int j = 0; j < 10; j++) begin
      bus(3'd5, 0, 32'd0);       expect_at("nb_steady", 1, 32'h00F, 1, 10'h00F);
    end
`endif

    // Reset mid-count: everything back to reset values
    step(1'b1, 1'b0, 3'd0, 1'b0, 32'd0); expect_at("midrst_a", 1, 32'd0, 1, 10'h155);
    step(1'b1, 1'b1, 3'd5, 1'b0, 32'd0); expect_at("midrst_b", 1, 32'd0, 1, 10'h155);
    bus(3'd1, 0, 32'd0);         expect_at("midrst_mask_rd", 1, 32'd0, 1, 10'h155);
    bus(3'd0, 0, 32'd0);         expect_at("midrst_data_rd", 1, 32'h155, 1, 10'h155);
`ifdef MP3PLAYER_LEDS_BLINK_EN
    bus(3'd4, 0, 32'd0);         expect_at("midrst_div_rd", 1, 32'd25000000, 1, 10'h155);
    bus(3'd1, 1, 32'h001);       expect_at("midrst_phase_on", 0, 32'd0, 1, 10'h155);
    bus(3'd5, 0, 32'd0);         expect_at("midrst_status", 1, 32'h155, 1, 10'h155);
`endif

    step(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
